// File: rtl/product_accumulator.sv
// Sums COUNT consecutive accepted unsigned products into an AW-bit result and presents
// it on a held valid/ready port with a sticky wrap-around flag.
module product_accumulator #(
  parameter int unsigned PW    = 16,
  parameter int unsigned AW    = 24,
  parameter int unsigned COUNT = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [PW-1:0] in_p_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] out_sum_o,
  output logic          out_ovf_o,
  output logic          busy_o
);

  localparam int unsigned CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LastCnt = CW'(COUNT - 1);

  typedef enum logic {StAccum, StHold} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   out_sum_q, out_sum_d;
  logic            out_ovf_q, out_ovf_d;

  logic [AW:0]     sum_ext;
  logic            accept;

  // One extra bit captures the carry out of the accumulator's top bit.
  assign sum_ext = {1'b0, acc_q} + {{(AW + 1 - PW){1'b0}}, in_p_i};
  assign accept  = in_valid_i && (state_q == StAccum);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    if (clear_i) begin
      state_d     = StAccum;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
      out_sum_d   = '0;
      out_ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            acc_d = sum_ext[AW-1:0];
            ovf_d = ovf_q | sum_ext[AW];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LastCnt) begin
              state_d     = StHold;
              out_valid_d = 1'b1;
              out_sum_d   = sum_ext[AW-1:0];
              out_ovf_d   = ovf_q | sum_ext[AW];
            end
          end
        end
        StHold: begin
          // The handshake cycle deliberately accepts no product.
          if (out_ready_i) begin
            state_d     = StAccum;
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StAccum);
  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_ovf_o   = out_ovf_q;
  assign busy_o      = (state_q == StAccum) && (cnt_q != '0);

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: three instances (COUNT=8, AW=17/COUNT=3, COUNT=1)
// with a result scoreboard filled when the last product of a group is driven.
module tb_product_accumulator;

  logic clk;
  logic rst;
  logic clear;
  logic        in_valid [3];
  logic [15:0] in_p     [3];
  logic        out_ready[3];

  logic        rdy0, val0, ovf0, busy0;
  logic        rdy1, val1, ovf1, busy1;
  logic        rdy2, val2, ovf2, busy2;
  logic [23:0] sum0, sum2;
  logic [16:0] sum1;

  typedef struct {
    logic [23:0] sum;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  product_accumulator #(.PW(16), .AW(24), .COUNT(8)) u_c8 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid[0]), .in_ready_o(rdy0),
    .in_p_i(in_p[0]), .out_valid_o(val0), .out_ready_i(out_ready[0]), .out_sum_o(sum0),
    .out_ovf_o(ovf0), .busy_o(busy0)
  );

  product_accumulator #(.PW(16), .AW(17), .COUNT(3)) u_c3 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid[1]), .in_ready_o(rdy1),
    .in_p_i(in_p[1]), .out_valid_o(val1), .out_ready_i(out_ready[1]), .out_sum_o(sum1),
    .out_ovf_o(ovf1), .busy_o(busy1)
  );

  product_accumulator #(.PW(16), .AW(24), .COUNT(1)) u_c1 (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_valid_i(in_valid[2]), .in_ready_o(rdy2),
    .in_p_i(in_p[2]), .out_valid_o(val2), .out_ready_i(out_ready[2]), .out_sum_o(sum2),
    .out_ovf_o(ovf2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] f_sum(input int d);
    if (d == 0) return sum0;
    if (d == 1) return {7'd0, sum1};
    return sum2;
  endfunction

  function automatic logic f_valid(input int d);
    if (d == 0) return val0;
    if (d == 1) return val1;
    return val2;
  endfunction

  function automatic logic f_ready(input int d);
    if (d == 0) return rdy0;
    if (d == 1) return rdy1;
    return rdy2;
  endfunction

  function automatic logic f_ovf(input int d);
    if (d == 0) return ovf0;
    if (d == 1) return ovf1;
    return ovf2;
  endfunction

  function automatic logic f_busy(input int d);
    if (d == 0) return busy0;
    if (d == 1) return busy1;
    return busy2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds in_valid until the product is accepted (bounded).
  task automatic send(input int d, input logic [15:0] p);
    int n;
    n = 0;
    in_valid[d] = 1'b1;
    in_p[d]     = p;
    while (!f_ready(d) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
    tick();
    in_valid[d] = 1'b0;
  endtask

  task automatic push_exp(input logic [23:0] s, input logic o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    sb.push_back(e);
  endtask

  // Waits (bounded) for out_valid, then checks the oldest scoreboard entry.
  task automatic expect_out(input int d, input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!f_valid(d) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, f_valid(d)}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, {8'd0, f_sum(d)}, {8'd0, e.sum});
      chk({tag, "_ovf"}, {31'd0, f_ovf(d)}, {31'd0, e.ovf});
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_valid"}, {31'd0, f_valid(d)}, 32'd0);
    chk({tag, "_sum"},   {8'd0, f_sum(d)},    32'd0);
    chk({tag, "_ovf"},   {31'd0, f_ovf(d)},   32'd0);
    chk({tag, "_busy"},  {31'd0, f_busy(d)},  32'd0);
    chk({tag, "_ready"}, {31'd0, f_ready(d)}, 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_p[i]      = '0;
      out_ready[i] = 1'b0;
    end
    tick();
    tick();
    chk_idle(0, "reset_c8");
    chk_idle(1, "reset_c3");
    chk_idle(2, "reset_c1");
    rst = 1'b0;
    tick();

    // T1: eight back-to-back 255*255 products
    out_ready[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        chk("t1_no_early_valid", {31'd0, f_valid(0)}, 32'd0);
        push_exp(24'h07F008, 1'b0);
      end
      send(0, 16'hFE01);
      if (i == 0) chk("t1_busy", {31'd0, f_busy(0)}, 32'd1);
    end
    chk("t1_latency", {31'd0, f_valid(0)}, 32'd1);
    expect_out(0, "t1");
    tick();
    chk("t1_drop", {31'd0, f_valid(0)}, 32'd0);

    // T2: backpressure, with a product offered during HOLD that must be ignored
    out_ready[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(24'd800, 1'b0);
      send(0, 16'd100);
    end
    expect_out(0, "t2");
    in_valid[0] = 1'b1;
    in_p[0]     = 16'd5;
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", {31'd0, f_valid(0)}, 32'd1);
      chk("t2_hold_sum",   {8'd0, f_sum(0)},    32'd800);
      chk("t2_hold_ready", {31'd0, f_ready(0)}, 32'd0);
      tick();
    end
    out_ready[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    chk("t2_release", {31'd0, f_valid(0)}, 32'd0);
    chk("t2_no_bubble_accept", {31'd0, f_busy(0)}, 32'd0);
    chk("t2_ready_back", {31'd0, f_ready(0)}, 32'd1);

    // T3: values 1..8 with two idle cycles between them
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push_exp(24'd36, 1'b0);
      send(0, 16'(i));
      if (i < 8) begin
        in_p[0] = 16'($urandom);
        tick();
        tick();
      end
    end
    expect_out(0, "t3");
    tick();
    chk("t3_drop", {31'd0, f_valid(0)}, 32'd0);
    chk("t3_sum_kept", {8'd0, f_sum(0)}, 32'd36);

    // T4: wrap-around in a 17-bit accumulator, then a clean group
    out_ready[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) push_exp(24'h00FA03, 1'b1);
      send(1, 16'hFE01);
    end
    expect_out(1, "t4_ovf");
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) push_exp(24'd6, 1'b0);
      send(1, 16'(i));
    end
    expect_out(1, "t4_clean");
    tick();

    // T5: rst mid-group
    for (int i = 0; i < 3; i++) send(0, 16'd100);
    chk("t5_busy", {31'd0, f_busy(0)}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle(0, "t5_rst");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(24'd8, 1'b0);
      send(0, 16'd1);
    end
    expect_out(0, "t5_rst_group");
    tick();

    // T5: clear mid-group, with a product offered in the clear cycle
    for (int i = 0; i < 3; i++) send(0, 16'd100);
    clear       = 1'b1;
    in_valid[0] = 1'b1;
    in_p[0]     = 16'd100;
    tick();
    clear       = 1'b0;
    in_valid[0] = 1'b0;
    chk_idle(0, "t5_clr");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push_exp(24'd8, 1'b0);
      send(0, 16'd1);
    end
    expect_out(0, "t5_clr_group");
    tick();

    // T6: COUNT=1, then rst and clear while holding
    out_ready[2] = 1'b0;
    push_exp(24'h00FFFF, 1'b0);
    send(2, 16'hFFFF);
    chk("t6_latency", {31'd0, f_valid(2)}, 32'd1);
    expect_out(2, "t6");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle(2, "t6_rst_hold");
    push_exp(24'd7, 1'b0);
    send(2, 16'd7);
    expect_out(2, "t6_b");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle(2, "t6_clr_hold");

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
